// File: rtl/posit_extract_raw_es3_pkg.sv
// Shared constants and the serialized raw-value layout for the es=3 posit datapath.
// Every es3 block that produces or consumes the 38-bit {sgn, scale, fraction, inf, zero} word imports this.
package posit_defines_es3;

    localparam int NBITS = 32;
    localparam int ES    = 3;
    localparam int FBITS = NBITS - 1 - 2 - ES;
    localparam int SBITS = 9;
    localparam int POSIT_SERIALIZED_WIDTH_ES3 = 1 + SBITS + FBITS + 2;

    localparam int SGN_POS   = 37;
    localparam int SCALE_MSB = 36;
    localparam int SCALE_LSB = 28;
    localparam int FRAC_MSB  = 27;
    localparam int FRAC_LSB  = 2;
    localparam int INF_POS   = 1;
    localparam int ZERO_POS  = 0;

    typedef struct packed {
        logic                    sgn;
        logic signed [SBITS-1:0] scale;
        logic [FBITS-1:0]        fraction;
        logic                    inf;
        logic                    zero;
    } value_t;

endpackage

// File: rtl/posit_extract_raw_es3_if.sv
// Operand-in / raw-value-out stream bundle of the es3 posit extractor.
// The master drives posit words and strobes; the slave returns decoded values.
interface posit_extract_raw_es3_if;
    import posit_defines_es3::*;

    logic [NBITS-1:0]                      in1;
    logic                                  in1_truncated;
    logic                                  start;
    logic [POSIT_SERIALIZED_WIDTH_ES3-1:0] result;
    logic                                  done;
    logic                                  truncated;

    modport master (
        output in1, in1_truncated, start,
        input  result, done, truncated
    );

    modport slave (
        input  in1, in1_truncated, start,
        output result, done, truncated
    );

endinterface

// File: rtl/posit_extract_raw_es3_regime.sv
// Combinational leading-run counter: length of the run of bits equal to pol,
// scanned from the MSB of vec downward (31 when the whole vector matches).
module posit_regime_count
    import posit_defines_es3::*;
(
    input  logic [NBITS-2:0] vec,
    input  logic             pol,
    output logic [4:0]       run_len
);

    logic [NBITS-2:0] flipped;

    // Flipping by polarity turns the run into leading zeros of one vector.
    for (genvar gi = 0; gi < NBITS - 1; gi++) begin : g_flip
        assign flipped[gi] = vec[gi] ^ pol;
    end

    always_comb begin
        run_len = 5'd31;
        for (int i = 0; i < NBITS - 1; i++) begin
            if (flipped[i]) begin
                run_len = 5'(NBITS - 2 - i);
            end
        end
    end

endmodule

// File: rtl/posit_extract_raw_es3.sv
// Three-stage es=3 posit decoder: sign/specials, regime strip, scale/fraction assembly.
// One operand per cycle; done is start delayed through the pipe, data stages run freely.
module posit_extract_raw_es3 #(
    parameter int NBITS = 32,
    parameter int ES    = 3,
    parameter int FBITS = NBITS - 1 - 2 - ES
) (
    input  logic                     clk,
    input  logic                     reset_n,
    posit_extract_raw_es3_if.slave   bus
);

    localparam int RW  = posit_defines_es3::POSIT_SERIALIZED_WIDTH_ES3;
    localparam int MW  = NBITS - 1;
    localparam int KW  = posit_defines_es3::SBITS - ES;
    localparam int RMW = ES + FBITS;

    if (NBITS != 32 || ES != 3 || FBITS != NBITS - 1 - 2 - ES) begin : g_bad_params
        $error("posit_extract_raw_es3 supports only NBITS=32, ES=3, FBITS=26");
    end

    logic           s0_valid_reg, s0_sgn_reg, s0_zero_reg, s0_inf_reg, s0_trunc_reg;
    logic [MW-1:0]  s0_mag_reg;
    logic [MW-1:0]  s0_mag_next;

    logic           s1_valid_reg, s1_sgn_reg, s1_zero_reg, s1_inf_reg, s1_trunc_reg;
    logic [KW-1:0]  s1_k_reg;
    logic [RMW-1:0] s1_rem_reg;
    logic [KW-1:0]  k_next;
    logic [RMW-1:0] rem_next;
    logic [4:0]     run_len;
    logic [5:0]     run_ext, shamt;

    logic           done_reg, trunc_reg;
    logic [RW-1:0]  result_reg, result_next;

    // Low bits of the 32-bit two's complement equal the 31-bit negation of the low bits.
    assign s0_mag_next = bus.in1[NBITS-1] ? (~bus.in1[MW-1:0] + MW'(1)) : bus.in1[MW-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s0_valid_reg <= 1'b0;
            s0_sgn_reg   <= 1'b0;
            s0_zero_reg  <= 1'b0;
            s0_inf_reg   <= 1'b0;
            s0_trunc_reg <= 1'b0;
            s0_mag_reg   <= '0;
        end else begin
            s0_valid_reg <= (bus.start === 1'b1);
            s0_sgn_reg   <= bus.in1[NBITS-1];
            s0_zero_reg  <= (bus.in1 == '0);
            s0_inf_reg   <= (bus.in1 == {1'b1, {MW{1'b0}}});
            s0_trunc_reg <= bus.in1_truncated;
            s0_mag_reg   <= s0_mag_next;
        end
    end

    posit_regime_count u_regime_count (
        .vec     (s0_mag_reg),
        .pol     (s0_mag_reg[MW-1]),
        .run_len (run_len)
    );

    // An all-zero magnitude only occurs for zero/NaR or a freshly cleared pipe;
    // forcing k=0 keeps the assembled result at zero in the cleared case.
    always_comb begin
        run_ext = {1'b0, run_len};
        shamt   = run_ext + 6'd1;
        if (s0_mag_reg == '0) begin
            k_next = '0;
        end else if (s0_mag_reg[MW-1]) begin
            k_next = run_ext - 6'd1;
        end else begin
            k_next = 6'd0 - run_ext;
        end
        rem_next = RMW'((s0_mag_reg << shamt) >> 2);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_reg <= 1'b0;
            s1_sgn_reg   <= 1'b0;
            s1_zero_reg  <= 1'b0;
            s1_inf_reg   <= 1'b0;
            s1_trunc_reg <= 1'b0;
            s1_k_reg     <= '0;
            s1_rem_reg   <= '0;
        end else begin
            s1_valid_reg <= s0_valid_reg;
            s1_sgn_reg   <= s0_sgn_reg;
            s1_zero_reg  <= s0_zero_reg;
            s1_inf_reg   <= s0_inf_reg;
            s1_trunc_reg <= s0_trunc_reg;
            s1_k_reg     <= k_next;
            s1_rem_reg   <= rem_next;
        end
    end

    // 8*k + exp has zero low bits in 8*k, so the scale is just {k, exp}.
    always_comb begin
        result_next = '0;
        if (s1_zero_reg) begin
            result_next[posit_defines_es3::ZERO_POS] = 1'b1;
        end else if (s1_inf_reg) begin
            result_next[posit_defines_es3::INF_POS] = 1'b1;
        end else begin
            result_next[posit_defines_es3::SGN_POS] = s1_sgn_reg;
            result_next[posit_defines_es3::SCALE_MSB:posit_defines_es3::SCALE_LSB] =
                {s1_k_reg, s1_rem_reg[RMW-1 -: ES]};
            result_next[posit_defines_es3::FRAC_MSB:posit_defines_es3::FRAC_LSB] =
                s1_rem_reg[FBITS-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_reg   <= 1'b0;
            trunc_reg  <= 1'b0;
            result_reg <= '0;
        end else begin
            done_reg   <= s1_valid_reg;
            trunc_reg  <= s1_trunc_reg;
            result_reg <= result_next;
        end
    end

    assign bus.result    = result_reg;
    assign bus.done      = done_reg;
    assign bus.truncated = trunc_reg;

endmodule
